// File: rtl/stopwatch_ctrl_if.sv
// Stopwatch control bus: tick/button inputs toward the controller,
// BCD time digits and mode flags back toward the display mux.
interface stopwatch_ctrl_if;
    logic       tick_1hz;
    logic       tick_2hz;
    logic       btn_pause;
    logic       btn_clear;
    logic       adj;
    logic       sel;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       paused;
    logic       adj_active;

    // Side that drives the ticks/buttons and reads the time
    modport master (
        output tick_1hz, tick_2hz, btn_pause, btn_clear, adj, sel,
        input  min_tens, min_ones, sec_tens, sec_ones, paused, adj_active
    );

    // Stopwatch controller side
    modport slave (
        input  tick_1hz, tick_2hz, btn_pause, btn_clear, adj, sel,
        output min_tens, min_ones, sec_tens, sec_ones, paused, adj_active
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch MM:SS BCD sequencer with RUN / PAUSED / ADJUST modes.
// RUN counts on tick_1hz with seconds->minutes carry; ADJUST steps the
// selected field on tick_2hz without carry; PAUSED holds.
module stopwatch_ctrl #(
    parameter int unsigned MIN_LIMIT    = 59,
    parameter bit          START_PAUSED = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    stopwatch_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {StRun, StPaused, StAdjust} state_e;

    localparam state_e     ResetState = START_PAUSED ? StPaused : StRun;
    localparam logic [7:0] MinLimBcd  = {4'(MIN_LIMIT / 10), 4'(MIN_LIMIT % 10)};

    state_e     state_q, state_d;
    logic       pause_prev_q;
    logic [7:0] min_q, min_d;
    logic [7:0] sec_q, sec_d;
    logic       pause_rise;

    // Seconds step: 59 wraps to 00
    function automatic logic [7:0] sec_inc(input logic [7:0] v);
        if (v == 8'h59)         return 8'h00;
        else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        else                     return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Minutes step: MIN_LIMIT wraps to 00
    function automatic logic [7:0] min_inc(input logic [7:0] v);
        if (v == MinLimBcd)      return 8'h00;
        else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        else                     return {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign pause_rise = bus.btn_pause & ~pause_prev_q;

    // Mode transitions; adj dominates the pause edge, pause ignored in ADJUST
    always_comb begin
        state_d = state_q;
        case (state_q)
            StRun: begin
                if (bus.adj)         state_d = StAdjust;
                else if (pause_rise) state_d = StPaused;
            end
            StPaused: begin
                if (bus.adj)         state_d = StAdjust;
                else if (pause_rise) state_d = StRun;
            end
            StAdjust: begin
                if (!bus.adj)        state_d = StPaused;
            end
            default: state_d = ResetState;
        endcase
    end

    // Time update, decided by the pre-transition state; clear drops ticks
    always_comb begin
        min_d = min_q;
        sec_d = sec_q;
        if (bus.btn_clear) begin
            min_d = 8'h00;
            sec_d = 8'h00;
        end else begin
            case (state_q)
                StRun: begin
                    if (bus.tick_1hz) begin
                        sec_d = sec_inc(sec_q);
                        if (sec_q == 8'h59) min_d = min_inc(min_q);
                    end
                end
                StAdjust: begin
                    if (bus.tick_2hz) begin
                        if (bus.sel) sec_d = sec_inc(sec_q);
                        else         min_d = min_inc(min_q);
                    end
                end
                default: ;
            endcase
        end
    end

    // State, pause-edge history and time registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ResetState;
            pause_prev_q <= 1'b1;  // a button held through reset must not toggle
            min_q        <= 8'h00;
            sec_q        <= 8'h00;
        end else begin
            state_q      <= state_d;
            pause_prev_q <= bus.btn_pause;
            min_q        <= min_d;
            sec_q        <= sec_d;
        end
    end

    assign bus.min_tens   = min_q[7:4];
    assign bus.min_ones   = min_q[3:0];
    assign bus.sec_tens   = sec_q[7:4];
    assign bus.sec_ones   = sec_q[3:0];
    assign bus.paused     = (state_q == StPaused);
    assign bus.adj_active = (state_q == StAdjust);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: a per-cycle vector table plus
// hand-written multi-cycle sequences. A second instance with MIN_LIMIT=9
// shares the same stimulus to check the minute wrap limit.
module tb_stopwatch_ctrl;

    typedef struct packed {
        logic rst_n;
        logic t1;
        logic t2;
        logic bp;
        logic bc;
        logic adj;
        logic sel;
    } in_t;

    typedef struct {
        in_t         in;
        logic [15:0] t;
        logic        p;
        logic        a;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    vec_t vq[$];

    stopwatch_ctrl_if sw_if ();
    stopwatch_ctrl_if sw9_if ();

    stopwatch_ctrl #(.MIN_LIMIT(59), .START_PAUSED(1'b0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sw_if)
    );

    stopwatch_ctrl #(.MIN_LIMIT(9), .START_PAUSED(1'b0)) dut9 (
        .clk   (clk),
        .reset (reset),
        .bus   (sw9_if)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic in_t mk(input bit r, input bit t1, input bit t2, input bit bp,
                               input bit bc, input bit adj, input bit sel);
        in_t v;
        v.rst_n = r; v.t1 = t1; v.t2 = t2; v.bp = bp; v.bc = bc; v.adj = adj; v.sel = sel;
        return v;
    endfunction

    // Drive one cycle of inputs to both instances, then sample 1 ns after the edge
    task automatic apply(input in_t v);
        reset            = v.rst_n;
        sw_if.tick_1hz   = v.t1;  sw9_if.tick_1hz  = v.t1;
        sw_if.tick_2hz   = v.t2;  sw9_if.tick_2hz  = v.t2;
        sw_if.btn_pause  = v.bp;  sw9_if.btn_pause = v.bp;
        sw_if.btn_clear  = v.bc;  sw9_if.btn_clear = v.bc;
        sw_if.adj        = v.adj; sw9_if.adj       = v.adj;
        sw_if.sel        = v.sel; sw9_if.sel       = v.sel;
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input bit r, input bit t1, input bit t2, input bit bp,
                       input bit bc, input bit adj, input bit sel);
        apply(mk(r, t1, t2, bp, bc, adj, sel));
    endtask

    task automatic check(input string name, input logic [15:0] t, input logic p,
                         input logic a);
        logic [17:0] act, exp;
        act = {sw_if.min_tens, sw_if.min_ones, sw_if.sec_tens, sw_if.sec_ones,
               sw_if.paused, sw_if.adj_active};
        exp = {t, p, a};
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h:%h p=%b a=%b, want %h:%h p=%b a=%b", name,
                     act[17:10], act[9:2], act[1], act[0], t[15:8], t[7:0], p, a);
        end
    endtask

    task automatic check9(input string name, input logic [15:0] t, input logic p,
                          input logic a);
        logic [17:0] act, exp;
        act = {sw9_if.min_tens, sw9_if.min_ones, sw9_if.sec_tens, sw9_if.sec_ones,
               sw9_if.paused, sw9_if.adj_active};
        exp = {t, p, a};
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h:%h p=%b a=%b, want %h:%h p=%b a=%b", name,
                     act[17:10], act[9:2], act[1], act[0], t[15:8], t[7:0], p, a);
        end
    endtask

    task automatic add(input bit r, input bit t1, input bit t2, input bit bp, input bit bc,
                       input bit adj, input bit sel, input logic [15:0] t, input logic p,
                       input logic a);
        vec_t v;
        v.in = mk(r, t1, t2, bp, bc, adj, sel);
        v.t = t; v.p = p; v.a = a;
        vq.push_back(v);
    endtask

    task automatic do_reset();
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        //   r t1 t2 bp bc adj sel   time      p  a
        add(0, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0, 16'h0001, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 16'h0001, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0, 16'h0002, 0, 0);
        add(1, 0, 0, 1, 0, 0, 0, 16'h0002, 1, 0);  // pause edge
        add(1, 1, 0, 1, 0, 0, 0, 16'h0002, 1, 0);  // held: no toggle, tick ignored
        add(1, 1, 0, 0, 0, 0, 0, 16'h0002, 1, 0);
        add(1, 0, 0, 1, 0, 0, 0, 16'h0002, 0, 0);  // resume
        add(1, 1, 0, 0, 0, 0, 0, 16'h0003, 0, 0);
        add(1, 1, 0, 0, 0, 1, 1, 16'h0004, 0, 1);  // RUN tick counts as it enters ADJUST
        add(1, 0, 1, 0, 0, 1, 1, 16'h0005, 0, 1);
        add(1, 0, 1, 0, 0, 1, 0, 16'h0105, 0, 1);
        add(1, 1, 0, 0, 0, 1, 0, 16'h0105, 0, 1);  // 1 Hz ignored in ADJUST
        add(1, 0, 0, 1, 0, 1, 0, 16'h0105, 0, 1);  // pause edge ignored in ADJUST
        add(1, 0, 0, 0, 0, 0, 0, 16'h0105, 1, 0);  // leave ADJUST -> PAUSED
        add(1, 1, 0, 1, 0, 0, 0, 16'h0105, 0, 0);  // PAUSED tick ignored, then RUN
        add(1, 1, 0, 0, 1, 0, 0, 16'h0000, 0, 0);  // clear drops tick
        add(1, 1, 0, 0, 1, 0, 0, 16'h0000, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0, 16'h0001, 0, 0);
        add(1, 0, 0, 1, 1, 0, 0, 16'h0000, 1, 0);  // clear with transition
        add(1, 1, 0, 0, 0, 0, 0, 16'h0000, 1, 0);

        foreach (vq[i]) begin
            apply(vq[i].in);
            check($sformatf("vec%0d", i), vq[i].t, vq[i].p, vq[i].a);
        end

        // Reset and 61 seconds of counting
        do_reset();
        check("reset_state", 16'h0000, 0, 0);
        repeat (61) cyc(1, 1, 0, 0, 0, 0, 0);
        check("count_61", 16'h0101, 0, 0);

        // Preload 59:59 via ADJUST; MIN_LIMIT=9 instance lands on 09:59
        do_reset();
        cyc(1, 0, 0, 0, 0, 1, 0);
        repeat (59) cyc(1, 0, 1, 0, 0, 1, 0);
        repeat (59) cyc(1, 0, 1, 0, 0, 1, 1);
        check("preload_5959", 16'h5959, 0, 1);
        check9("preload_0959_lim9", 16'h0959, 0, 1);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 0, 0);
        check("preload_run", 16'h5959, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0);
        check("wrap_5959", 16'h0000, 0, 0);
        check9("wrap_0959_lim9", 16'h0000, 0, 0);

        // Seconds wrap in ADJUST has no carry
        do_reset();
        repeat (58) cyc(1, 1, 0, 0, 0, 0, 0);
        check("reach_0058", 16'h0058, 0, 0);
        cyc(1, 0, 0, 0, 0, 1, 1);
        cyc(1, 0, 1, 0, 0, 1, 1);
        cyc(1, 0, 1, 0, 0, 1, 1);
        check("adj_sec_wrap", 16'h0000, 0, 1);
        cyc(1, 0, 1, 0, 0, 1, 1);
        cyc(1, 1, 0, 0, 0, 1, 1);
        check("adj_ignore_1hz", 16'h0001, 0, 1);
        cyc(1, 0, 0, 0, 0, 0, 1);
        check("adj_exit_paused", 16'h0001, 1, 0);

        // Tick and pause edge in the same cycle; clear held across ticks
        do_reset();
        repeat (9) cyc(1, 1, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 1, 0, 0, 0);
        check("tick_with_pause", 16'h0010, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 0, 0);
        check("resume_run", 16'h0010, 0, 0);
        repeat (3) cyc(1, 1, 0, 0, 1, 0, 0);
        check("clear_hold", 16'h0000, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0);
        check("after_clear", 16'h0001, 0, 0);

        // Reset mid-ADJUST with pause held
        do_reset();
        cyc(1, 0, 0, 0, 0, 1, 0);
        repeat (12) cyc(1, 0, 1, 0, 0, 1, 0);
        repeat (34) cyc(1, 0, 1, 0, 0, 1, 1);
        cyc(1, 0, 0, 1, 0, 1, 1);
        check("adj_1234", 16'h1234, 0, 1);
        cyc(0, 0, 0, 1, 0, 0, 0);
        check("reset_mid_adj", 16'h0000, 0, 0);
        cyc(1, 0, 0, 1, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 0, 0);
        check("held_pause_no_toggle", 16'h0000, 0, 0);
        cyc(1, 1, 0, 1, 0, 0, 0);
        check("held_pause_counts", 16'h0001, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
